arbitrated_egress: RTL and testbench
====================================

Name: arbitrated_egress

Overview:
- Downstream consumer of the arbitrated multi-FIFO stage.
- Captures the muxed data word and one-hot grant each cycle and encodes the grant into a source tag.
- Buffers {data, tag} in a 2-entry skid buffer and presents it on a valid/ready output port.
- Drives the arbiter's per-FIFO request vector as backpressure, so a grant is only issued when a buffer slot is guaranteed free.

Parameters:
- NUM_FIFOS, 4, number of arbitrated source FIFOs; power of two, >=2.
- WIDTH, 8, data word width.
- TAGWIDTH, $clog2(NUM_FIFOS), source tag width.
- MAX_BURST, 4, maximum consecutive beats from one source; used only with EGRESS_FAIR_EN; >=1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- gnt  input  NUM_FIFOS  one-hot grant from the arbiter; a set bit pops that FIFO this cycle.
- data_in  input  WIDTH  muxed FIFO head for the granted source, valid when |gnt.
- reqs  output  NUM_FIFOS  request enables to the arbiter (backpressure).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  WIDTH  head entry data.
- out_tag  output  TAGWIDTH  head entry source index.
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Storage:
  - Two entries (head, skid), each {data, tag}; occupancy cnt ranges 0..2.
  - Strict FIFO order.
- accept = (cnt != 2), derived from registered state only; no combinational path from out_ready or gnt to reqs.
- reqs = {NUM_FIFOS{accept}} & ~fair_mask, where fair_mask = 0 without the feature; reqs = 0 while rst is high.
- Write condition: wr = |gnt & accept & onehot(gnt). On wr, the entry stores data_in and tag = binary index of the set gnt bit. Latency: the word is on out_data the cycle after the grant if the buffer was empty.
- Read condition: rd = out_valid & out_ready.
- Occupancy update:
  - cnt += wr - rd.
  - Simultaneous wr and rd at cnt=1: the new word becomes head next cycle.
  - At cnt=2 with rd: skid moves to head, and wr is impossible (accept = 0).
- out_valid = (cnt != 0). out_data and out_tag are held stable while out_valid & !out_ready.
- err:
  - Set and held until rst on any cycle with |gnt & !accept (grant while backpressured) or with gnt not one-hot.
  - The offending word is dropped and cnt is not incremented for it.
  - A legal read in the same cycle still proceeds.
- Reset values: cnt = 0, out_valid = 0, out_data = 0, out_tag = 0, err = 0, reqs = 0. Internal burst state is cleared.
- Reset mid-operation: buffered entries are discarded. The upstream scoreboard is reset by the same rst, so no reconciliation is required.
- Formal build (FORMAL defined):
  - Assert cnt <= 2.
  - Assert out_data/out_tag stability under stall.
  - Assert !err whenever the upstream arbiter obeys reqs.

Optional Feature:
- Macro: EGRESS_FAIR_EN.
- Defined: burst limiter.
  - Registers last_tag and run (width $clog2(MAX_BURST+1)).
  - On wr: if tag == last_tag, run++; otherwise last_tag = tag and run = 1.
  - When run == MAX_BURST, fair_mask = one-hot(last_tag) for exactly one cycle; run then clears to 0 regardless of whether another source was granted.
  - A grant on the masked bit while masked sets err.
  - Reset: last_tag = 0, run = 0.
- Undefined: fair_mask = 0; last_tag and run are not instantiated; MAX_BURST is ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, gnt=0 -> reqs=0 during reset, then reqs=4'b1111; out_valid=0, err=0.
- Single beat: gnt=4'b0100, data_in=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_tag=2; following cycle out_valid=0.
- Backpressure: out_ready=0; grants 4'b0001/8'h11 then 4'b1000/8'h22 -> cnt=2, reqs=0, head 8'h11/tag 0 held stable. Then out_ready=1 -> 8'h11 then 8'h22/tag 3 in order, and reqs returns to 4'b1111 the cycle after the first pop.
- Simultaneous push/pop: cnt=1 (head 8'h33), out_ready=1, gnt=4'b0010/8'h44 -> next cycle head=8'h44, tag=1, cnt=1.
- Violation: at cnt=2, drive gnt=4'b0001 -> err=1 sticky, cnt stays 2, word dropped. Separately, gnt=4'b0011 at cnt=0 -> err=1, cnt=0.
- EGRESS_FAIR_EN, MAX_BURST=4: five back-to-back grants attempted on source 1 with out_ready=1 -> after the 4th beat reqs=4'b1101 for one cycle, then 4'b1111 and run=0; a grant on bit 1 during the masked cycle sets err.

Source files
------------

// File: rtl/arbitrated_egress.sv
// Egress buffer behind the multi-FIFO arbiter: 2-entry skid, grant-to-tag, backpressure.
// Optional burst limiter enabled by defining EGRESS_FAIR_EN.
module arbitrated_egress #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] gnt,
    input  logic [WIDTH-1:0]     data_in,
    output logic [NUM_FIFOS-1:0] reqs,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAGWIDTH-1:0]  out_tag,
    output logic                 err
);

    logic [1:0]           cnt;
    logic [WIDTH-1:0]     head_data, skid_data;
    logic [TAGWIDTH-1:0]  head_tag, skid_tag, wr_tag;
    logic [NUM_FIFOS-1:0] fair_mask;
    logic                 accept, onehot, masked_hit, wr, rd, bad;

    always_comb begin
        wr_tag = '0;
        for (int i = 0; i < NUM_FIFOS; i++)
            if (gnt[i]) wr_tag = TAGWIDTH'(i);
    end

    // accept depends on registered occupancy only, so reqs has no path from gnt/out_ready
    assign accept     = (cnt != 2'd2);
    assign onehot     = (|gnt) && ((gnt & (gnt - NUM_FIFOS'(1))) == '0);
    assign masked_hit = |(gnt & fair_mask);
    assign wr         = onehot & accept & ~masked_hit;
    assign bad        = (|gnt) & ~wr;
    assign rd         = out_valid & out_ready;
    assign reqs       = rst ? '0 : ({NUM_FIFOS{accept}} & ~fair_mask);
    assign out_valid  = (cnt != 2'd0);
    assign out_data   = head_data;
    assign out_tag    = head_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 2'd0;
            head_data <= '0;
            head_tag  <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
            err       <= 1'b0;
        end else begin
            if (bad) err <= 1'b1;
            if (rd && wr) begin
                head_data <= data_in;
                head_tag  <= wr_tag;
            end else if (rd) begin
                head_data <= skid_data;
                head_tag  <= skid_tag;
                cnt       <= cnt - 2'd1;
            end else if (wr) begin
                if (cnt == 2'd0) begin
                    head_data <= data_in;
                    head_tag  <= wr_tag;
                end else begin
                    skid_data <= data_in;
                    skid_tag  <= wr_tag;
                end
                cnt <= cnt + 2'd1;
            end
        end
    end

`ifdef EGRESS_FAIR_EN
    localparam int RW = $clog2(MAX_BURST + 1);

    logic [RW-1:0]       run;
    logic [TAGWIDTH-1:0] last_tag;
    logic                limit;

    assign limit     = (run == RW'(MAX_BURST));
    assign fair_mask = limit ? (NUM_FIFOS'(1) << last_tag) : '0;

    // the masked cycle always clears run, even if another source was granted
    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= '0;
            last_tag <= '0;
        end else if (limit) begin
            run <= '0;
            if (wr) last_tag <= wr_tag;
        end else if (wr) begin
            if (wr_tag == last_tag) begin
                run <= run + RW'(1);
            end else begin
                last_tag <= wr_tag;
                run      <= RW'(1);
            end
        end
    end
`else
    assign fair_mask = '0;
`endif

`ifdef FORMAL
    always_ff @(posedge clk)
        if (!rst) assert (cnt <= 2'd2);

    assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_tag)));

    assume property (@(posedge clk)
        ((gnt & ~reqs) == '0) && $onehot0(gnt));

    assert property (@(posedge clk) disable iff (rst) !err);
`endif

endmodule

// File: tb/tb_arbitrated_egress.sv
// Self-checking bench: directed literal checks plus random traffic vs a queue model.
module tb_arbitrated_egress;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TW = 2;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  gnt;
    logic [W-1:0]  data_in;
    logic [N-1:0]  reqs;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          err;

    int errors = 0;
    int checks = 0;

    arbitrated_egress #(.NUM_FIFOS(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .data_in(data_in), .reqs(reqs),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .err(err)
    );

    always #5 clk = ~clk;

    // behavioural model: queue of {tag, data}
    logic [TW+W-1:0] mq[$];
    logic            m_err = 1'b0;
    int              m_run = 0;
    int              m_last = 0;
    bit              fair = 1'b0;

    initial begin
`ifdef EGRESS_FAIR_EN
        fair = 1'b1;
`endif
    end

    function automatic logic [N-1:0] m_mask();
        if (fair && m_run == MB) return N'(1) << m_last;
        return '0;
    endfunction

    function automatic logic [N-1:0] m_reqs();
        return (mq.size() < 2) ? ~m_mask() : '0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process, then advance the model with the inputs of this cycle
    always @(negedge clk) begin
        int  tag;
        bit  wrm, rdm;
        chk("m_reqs", reqs, rst ? 0 : m_reqs());
        chk("m_valid", out_valid, mq.size() != 0);
        chk("m_err", err, m_err);
        if (mq.size() != 0) begin
            chk("m_data", out_data, mq[0][W-1:0]);
            chk("m_tag", out_tag, mq[0][TW+W-1:W]);
        end
        if (rst) begin
            mq.delete();
            m_err  = 1'b0;
            m_run  = 0;
            m_last = 0;
        end else begin
            tag = $clog2(gnt);
            wrm = ($countones(gnt) == 1) && (mq.size() < 2) && ((gnt & m_mask()) == '0);
            rdm = (mq.size() != 0) && out_ready;
            if (gnt != '0 && !wrm) m_err = 1'b1;
            if (rdm) void'(mq.pop_front());
            if (wrm) mq.push_back({TW'(tag), data_in});
            if (fair) begin
                if (m_run == MB) begin
                    m_run = 0;
                    if (wrm) m_last = tag;
                end else if (wrm) begin
                    if (tag == m_last) m_run++;
                    else begin
                        m_last = tag;
                        m_run  = 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gnt = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        gnt = '0;
        data_in = '0;
        out_ready = 1'b0;
        step();
        chk("rst_reqs", reqs, 0);
        step();
        chk("rst_reqs2", reqs, 0);
        rst = 1'b0;
        step();
        chk("idle_reqs", reqs, 4'b1111);
        chk("idle_valid", out_valid, 0);
        chk("idle_err", err, 0);
        chk("idle_data", out_data, 0);
        chk("idle_tag", out_tag, 0);

        // single beat
        gnt = 4'b0100; data_in = 8'hA5; out_ready = 1'b1;
        step();
        gnt = '0;
        chk("sb_valid", out_valid, 1);
        chk("sb_data", out_data, 8'hA5);
        chk("sb_tag", out_tag, 2);
        step();
        chk("sb_empty", out_valid, 0);

        // backpressure
        out_ready = 1'b0;
        gnt = 4'b0001; data_in = 8'h11;
        step();
        gnt = 4'b1000; data_in = 8'h22;
        step();
        gnt = '0;
        chk("bp_reqs", reqs, 0);
        chk("bp_data", out_data, 8'h11);
        chk("bp_tag", out_tag, 0);
        step();
        chk("bp_hold", out_data, 8'h11);
        out_ready = 1'b1;
        step();
        chk("bp_data2", out_data, 8'h22);
        chk("bp_tag2", out_tag, 3);
        chk("bp_reqs2", reqs, 4'b1111);
        step();
        chk("bp_empty", out_valid, 0);

        // simultaneous push/pop at cnt=1
        out_ready = 1'b0;
        gnt = 4'b0001; data_in = 8'h33;
        step();
        gnt = 4'b0010; data_in = 8'h44; out_ready = 1'b1;
        step();
        gnt = '0;
        chk("pp_data", out_data, 8'h44);
        chk("pp_tag", out_tag, 1);
        chk("pp_valid", out_valid, 1);
        step();

        // grant while full
        out_ready = 1'b0;
        gnt = 4'b0001; data_in = 8'h55;
        step();
        gnt = 4'b0010; data_in = 8'h66;
        step();
        gnt = 4'b0001; data_in = 8'h77;
        step();
        gnt = '0;
        chk("full_err", err, 1);
        chk("full_head", out_data, 8'h55);
        out_ready = 1'b1;
        step();
        chk("full_next", out_data, 8'h66);
        step();
        chk("full_drop", out_valid, 0);
        chk("full_sticky", err, 1);

        // grant not one-hot
        do_reset();
        step();
        chk("clr_err", err, 0);
        gnt = 4'b0011;
        step();
        gnt = '0;
        chk("oh_err", err, 1);
        chk("oh_valid", out_valid, 0);

`ifdef EGRESS_FAIR_EN
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gnt = 4'b0010; data_in = W'(8'hB0 + i);
            step();
        end
        chk("fair_mask", reqs, 4'b1101);
        chk("fair_noerr", err, 0);
        gnt = 4'b0010;
        step();
        gnt = '0;
        chk("fair_reqs", reqs, 4'b1111);
        chk("fair_err", err, 1);
        step();
`endif

        // random traffic, mostly obeying the model's reqs
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            int s;
            rst = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            data_in = W'($urandom);
            r = m_reqs();
            gnt = '0;
            if ($urandom_range(0, 49) == 0) begin
                gnt = N'($urandom);
            end else if ($urandom_range(0, 3) != 0) begin
                s = $urandom_range(0, N - 1);
                if (r[s]) gnt = N'(1) << s;
            end
            step();
        end
        gnt = '0;
        rst = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
